// File: rtl/gen_counter_pkg.sv
// gen_counter_pkg: mode encodings and load clamping shared by the counter family
package gen_counter_pkg;
   localparam logic SAT_WRAP = 1'b0;
   localparam logic SAT_HOLD = 1'b1;
   localparam logic DIR_DOWN = 1'b0;
   localparam logic DIR_UP   = 1'b1;

   function automatic logic [31:0] clamp_load(input logic [31:0] value, input logic [31:0] max);
      return (value > max) ? max : value;
   endfunction
endpackage

// File: rtl/gen_counter_if.sv
// gen_counter_if: control inputs and registered outputs of gen_counter
interface gen_counter_if #(parameter int WIDTH = 8);
   logic             enable;
   logic             up_dn;
   logic             load;
   logic [WIDTH-1:0] load_val;
   logic             clr_flags;
   logic [WIDTH-1:0] counter_out;
   logic             overflow_out;
   logic             underflow_out;
   logic             tc_pulse;

   modport master (
      output enable, up_dn, load, load_val, clr_flags,
      input  counter_out, overflow_out, underflow_out, tc_pulse
   );
   modport slave (
      input  enable, up_dn, load, load_val, clr_flags,
      output counter_out, overflow_out, underflow_out, tc_pulse
   );
endinterface

// File: rtl/gen_counter_next.sv
// gen_counter_next: next-count and limit-event logic over the range 0..MAX
module gen_counter_next import gen_counter_pkg::*; #(
   parameter int               WIDTH = 8,
   parameter logic [WIDTH-1:0] MAX   = '1
) (
   input  logic [WIDTH-1:0] count,
   input  logic             up_dn,
   input  logic             enable,
   input  logic             mode,
   output logic [WIDTH-1:0] nxt,
   output logic             ovf_evt,
   output logic             udf_evt
);
   logic at_max, at_zero, hold;

   assign at_max  = count == MAX;
   assign at_zero = count == '0;
   assign hold    = mode == SAT_HOLD;
   assign ovf_evt = enable & (up_dn == DIR_UP) & at_max;
   assign udf_evt = enable & (up_dn == DIR_DOWN) & at_zero;

   // Limits are compared explicitly so a MAX below 2**WIDTH-1 wraps modulo MAX+1
   always_comb begin
      nxt = count;
      if (enable)
         nxt = (up_dn == DIR_UP)
             ? (at_max  ? (hold ? count : '0)  : count + WIDTH'(1))
             : (at_zero ? (hold ? count : MAX) : count - WIDTH'(1));
   end
endmodule

// File: rtl/gen_counter.sv
// gen_counter: parametrised up/down counter with load, wrap/saturate and sticky limit flags
module gen_counter import gen_counter_pkg::*; #(
   parameter int              WIDTH     = 8,
   parameter longint unsigned MAX_VAL   = (64'd1 << WIDTH) - 64'd1,
   parameter longint unsigned RESET_VAL = 0,
   parameter int              SATURATE  = 0
) (
   input  logic clk,
   input  logic reset_n,
   gen_counter_if.slave bus
);
   localparam logic [WIDTH-1:0] MAX  = WIDTH'(MAX_VAL);
   localparam logic [WIDTH-1:0] RST  = WIDTH'(RESET_VAL);
   localparam logic             MODE = (SATURATE != 0) ? SAT_HOLD : SAT_WRAP;

   logic [WIDTH-1:0] cnt, nxt, ld_cnt;
   logic ovf, udf, tc, ovf_evt, udf_evt, ovf_set, udf_set;

   gen_counter_next #(.WIDTH(WIDTH), .MAX(MAX)) u_next (
      .count   (cnt),
      .up_dn   (bus.up_dn),
      .enable  (bus.enable),
      .mode    (MODE),
      .nxt     (nxt),
      .ovf_evt (ovf_evt),
      .udf_evt (udf_evt)
   );

   assign ld_cnt  = WIDTH'(clamp_load(32'(bus.load_val), 32'(MAX)));
   // A load suppresses any step, so it can never raise a limit event
   assign ovf_set = ovf_evt & ~bus.load;
   assign udf_set = udf_evt & ~bus.load;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cnt <= RST;
         ovf <= 1'b0;
         udf <= 1'b0;
         tc  <= 1'b0;
      end else begin
         cnt <= bus.load ? ld_cnt : nxt;
         ovf <= (ovf & ~bus.clr_flags) | ovf_set;
         udf <= (udf & ~bus.clr_flags) | udf_set;
         tc  <= ovf_set | udf_set;
      end
   end

   assign bus.counter_out   = cnt;
   assign bus.overflow_out  = ovf;
   assign bus.underflow_out = udf;
   assign bus.tc_pulse      = tc;
endmodule

// File: tb/tb_gen_counter.sv
// tb_gen_counter: vector-table and scoreboard checks for wrap, saturate and full-width counters
module tb_gen_counter;
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst_a, rst_s, rst_f;
   gen_counter_if #(.WIDTH(4)) bus_a ();
   gen_counter_if #(.WIDTH(4)) bus_s ();
   gen_counter_if #(.WIDTH(8)) bus_f ();

   gen_counter #(.WIDTH(4), .MAX_VAL(9), .RESET_VAL(3), .SATURATE(0)) dut_a (.clk(clk), .reset_n(rst_a), .bus(bus_a));
   gen_counter #(.WIDTH(4), .MAX_VAL(9), .RESET_VAL(3), .SATURATE(1)) dut_s (.clk(clk), .reset_n(rst_s), .bus(bus_s));
   gen_counter #(.WIDTH(8), .MAX_VAL(255), .RESET_VAL(0), .SATURATE(0)) dut_f (.clk(clk), .reset_n(rst_f), .bus(bus_f));

   typedef struct {
      logic       en, ud, ld;
      logic [3:0] lv;
      logic       clr;
      logic [3:0] cnt;
      logic       ovf, udf, tc;
   } vec_t;

   vec_t vecs[15];
   vec_t sb[$];
   vec_t exp_v;
   int   n_cmp = 0;
   int   n_bad = 0;
   int   tcs;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic drive_a(input vec_t v);
      bus_a.enable    = v.en;
      bus_a.up_dn     = v.ud;
      bus_a.load      = v.ld;
      bus_a.load_val  = v.lv;
      bus_a.clr_flags = v.clr;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      {bus_a.enable, bus_a.up_dn, bus_a.load, bus_a.load_val, bus_a.clr_flags} = '0;
      {bus_s.enable, bus_s.up_dn, bus_s.load, bus_s.load_val, bus_s.clr_flags} = '0;
      {bus_f.enable, bus_f.up_dn, bus_f.load, bus_f.load_val, bus_f.clr_flags} = '0;
      rst_a = 1'b0; rst_s = 1'b0; rst_f = 1'b0;
      //          en    ud    ld    lv     clr   cnt    ovf   udf   tc
      vecs[0]  = '{1'b0, 1'b0, 1'b1, 4'd8,  1'b0, 4'd8,  1'b0, 1'b0, 1'b0};
      vecs[1]  = '{1'b1, 1'b1, 1'b0, 4'd0,  1'b0, 4'd9,  1'b0, 1'b0, 1'b0};
      vecs[2]  = '{1'b1, 1'b1, 1'b0, 4'd0,  1'b0, 4'd0,  1'b1, 1'b0, 1'b1};
      vecs[3]  = '{1'b1, 1'b1, 1'b0, 4'd0,  1'b0, 4'd1,  1'b1, 1'b0, 1'b0};
      vecs[4]  = '{1'b1, 1'b0, 1'b0, 4'd0,  1'b0, 4'd0,  1'b1, 1'b0, 1'b0};
      vecs[5]  = '{1'b1, 1'b0, 1'b0, 4'd0,  1'b0, 4'd9,  1'b1, 1'b1, 1'b1};
      vecs[6]  = '{1'b0, 1'b0, 1'b0, 4'd0,  1'b1, 4'd9,  1'b0, 1'b0, 1'b0};
      vecs[7]  = '{1'b1, 1'b1, 1'b1, 4'd14, 1'b0, 4'd9,  1'b0, 1'b0, 1'b0};
      vecs[8]  = '{1'b1, 1'b1, 1'b0, 4'd0,  1'b0, 4'd0,  1'b1, 1'b0, 1'b1};
      vecs[9]  = '{1'b1, 1'b0, 1'b1, 4'd5,  1'b1, 4'd5,  1'b0, 1'b0, 1'b0};
      vecs[10] = '{1'b0, 1'b1, 1'b0, 4'd0,  1'b0, 4'd5,  1'b0, 1'b0, 1'b0};
      vecs[11] = '{1'b0, 1'b0, 1'b1, 4'd0,  1'b0, 4'd0,  1'b0, 1'b0, 1'b0};
      vecs[12] = '{1'b1, 1'b0, 1'b0, 4'd0,  1'b1, 4'd9,  1'b0, 1'b1, 1'b1};
      vecs[13] = '{1'b1, 1'b1, 1'b0, 4'd0,  1'b0, 4'd0,  1'b1, 1'b1, 1'b1};
      vecs[14] = '{1'b0, 1'b0, 1'b1, 4'd9,  1'b0, 4'd9,  1'b1, 1'b1, 1'b0};

      tick(); tick();
      chk("reset cnt_a", bus_a.counter_out, 3);
      chk("reset ovf_a", bus_a.overflow_out, 0);
      chk("reset udf_a", bus_a.underflow_out, 0);
      chk("reset tc_a", bus_a.tc_pulse, 0);
      chk("reset cnt_s", bus_s.counter_out, 3);
      chk("reset cnt_f", bus_f.counter_out, 0);
      @(negedge clk);
      rst_a = 1'b1; rst_s = 1'b1; rst_f = 1'b1;

      for (int i = 0; i < 15; i++) begin
         drive_a(vecs[i]);
         sb.push_back(vecs[i]);
         tick();
         exp_v = sb.pop_front();
         chk($sformatf("vec%0d cnt", i), bus_a.counter_out, exp_v.cnt);
         chk($sformatf("vec%0d ovf", i), bus_a.overflow_out, exp_v.ovf);
         chk($sformatf("vec%0d udf", i), bus_a.underflow_out, exp_v.udf);
         chk($sformatf("vec%0d tc", i), bus_a.tc_pulse, exp_v.tc);
      end

      // asynchronous reset mid-count with a load pending
      bus_a.load = 1'b1; bus_a.load_val = 4'd7; bus_a.enable = 1'b0; bus_a.clr_flags = 1'b0;
      tick();
      chk("pre-rst cnt", bus_a.counter_out, 7);
      chk("pre-rst ovf", bus_a.overflow_out, 1);
      bus_a.load_val = 4'd5; bus_a.enable = 1'b1; bus_a.up_dn = 1'b1;
      #2 rst_a = 1'b0;
      #1;
      chk("async rst cnt", bus_a.counter_out, 3);
      chk("async rst ovf", bus_a.overflow_out, 0);
      chk("async rst udf", bus_a.underflow_out, 0);
      chk("async rst tc", bus_a.tc_pulse, 0);
      tick();
      chk("rst held cnt", bus_a.counter_out, 3);
      @(negedge clk);
      rst_a = 1'b1; bus_a.load = 1'b0;
      tick();
      chk("post-rst step", bus_a.counter_out, 4);

      // saturate mode held at the top limit
      bus_s.load = 1'b1; bus_s.load_val = 4'd9;
      tick();
      chk("sat load", bus_s.counter_out, 9);
      bus_s.load = 1'b0; bus_s.enable = 1'b1; bus_s.up_dn = 1'b1;
      for (int k = 0; k < 3; k++) begin
         bus_s.clr_flags = (k == 1);
         tick();
         chk($sformatf("sat%0d cnt", k), bus_s.counter_out, 9);
         chk($sformatf("sat%0d tc", k), bus_s.tc_pulse, 1);
         chk($sformatf("sat%0d ovf", k), bus_s.overflow_out, 1);
      end
      bus_s.enable = 1'b0; bus_s.clr_flags = 1'b1;
      tick();
      chk("sat clr ovf", bus_s.overflow_out, 0);
      chk("sat clr tc", bus_s.tc_pulse, 0);
      bus_s.clr_flags = 1'b0; bus_s.load = 1'b1; bus_s.load_val = 4'd0;
      tick();
      bus_s.load = 1'b0; bus_s.enable = 1'b1; bus_s.up_dn = 1'b0;
      for (int k = 0; k < 2; k++) begin
         tick();
         chk($sformatf("sat low%0d cnt", k), bus_s.counter_out, 0);
         chk($sformatf("sat low%0d udf", k), bus_s.underflow_out, 1);
         chk($sformatf("sat low%0d tc", k), bus_s.tc_pulse, 1);
      end
      bus_s.enable = 1'b0;
      tick();
      chk("sat low idle tc", bus_s.tc_pulse, 0);
      chk("sat low idle ovf", bus_s.overflow_out, 0);

      // full-width natural rollover
      bus_f.enable = 1'b1; bus_f.up_dn = 1'b1;
      tcs = 0;
      for (int k = 0; k < 256; k++) begin
         tick();
         tcs += int'(bus_f.tc_pulse);
         if (k == 254) begin
            chk("full 255 cnt", bus_f.counter_out, 255);
            chk("full 255 ovf", bus_f.overflow_out, 0);
         end
      end
      chk("full wrap cnt", bus_f.counter_out, 0);
      chk("full tc count", tcs, 1);
      chk("full ovf", bus_f.overflow_out, 1);
      bus_f.enable = 1'b0;
      tick();
      chk("full tc drop", bus_f.tc_pulse, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
